// File: rtl/exibidor_pkg.sv
// Shared constants for the sequence playback unit: state codes, default timings, timer sizing.
// The optional PISCA state exists only when EXIBIDOR_PISCA_FINAL_EN is defined.
package exibidor_pkg;

    localparam int unsigned T_ACESO_PADRAO   = 1000;
    localparam int unsigned T_APAGADO_PADRAO = 500;
    localparam int unsigned LARG_DADO        = 4;
    localparam int unsigned LARG_DB          = 4;

    // Encodings double as the db_estado codes shown on hexa7seg
    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ACESO   = 3'd2,
        APAGADO = 3'd3,
        FIM     = 3'd4
`ifdef EXIBIDOR_PISCA_FINAL_EN
        ,
        PISCA   = 3'd5
`endif
    } estado_t;

    function automatic int unsigned largura_timer(input int unsigned a, input int unsigned b);
        int unsigned maior;
        maior = (a > b) ? a : b;
        return $clog2(maior + 1);
    endfunction

endpackage

// File: rtl/contador_tempo.sv
// Loadable down-counter used as the on/off interval timer; fim flags a count of zero.
module contador_tempo #(
    parameter int unsigned LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               zera,
    input  logic               conta,
    input  logic [LARGURA-1:0] valor,
    output logic               fim
);

    logic [LARGURA-1:0] contagem;

    // zera reloads the interval; counting stops at zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (zera) begin
            contagem <= valor;
        end else if (conta && (contagem != '0)) begin
            contagem <= contagem - LARGURA'(1);
        end
    end

    assign fim = (contagem == '0);

endmodule

// File: rtl/exibidor_sequencia.sv
// Plays ROM[0..tamanho] on the LEDs, each value lit T_ACESO cycles then dark T_APAGADO cycles.
// Define EXIBIDOR_PISCA_FINAL_EN to add a final all-on flash (PISCA) before FIM.
module exibidor_sequencia
    import exibidor_pkg::*;
#(
    parameter int unsigned T_ACESO   = T_ACESO_PADRAO,
    parameter int unsigned T_APAGADO = T_APAGADO_PADRAO
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 iniciar,
    input  logic                 parar,
    input  logic [LARG_DADO-1:0] tamanho,
    input  logic [LARG_DADO-1:0] mem_dado,
    output logic [LARG_DADO-1:0] mem_endereco,
    output logic [LARG_DADO-1:0] leds,
    output logic                 ativo,
    output logic                 pronto,
    output logic [LARG_DB-1:0]   db_estado
);

    localparam int unsigned LARG_TIMER = largura_timer(T_ACESO, T_APAGADO);
    localparam logic [LARG_TIMER-1:0] CARGA_ACESO   = LARG_TIMER'(T_ACESO - 1);
    localparam logic [LARG_TIMER-1:0] CARGA_APAGADO = LARG_TIMER'(T_APAGADO - 1);

    estado_t                estado, estado_prox;
    logic [LARG_DADO-1:0]   ultimo, ultimo_prox;
    logic [LARG_DADO-1:0]   leds_prox, endereco_prox;
    logic                   ativo_prox, pronto_prox;
    logic [LARG_DB-1:0]     db_prox;
    logic                   t_zera, t_conta, t_fim;
    logic [LARG_TIMER-1:0]  t_valor;

    contador_tempo #(.LARGURA(LARG_TIMER)) u_timer (
        .clock (clock),
        .reset (reset),
        .zera  (t_zera),
        .conta (t_conta),
        .valor (t_valor),
        .fim   (t_fim)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= OCIOSO;
            ultimo       <= '0;
            leds         <= '0;
            mem_endereco <= '0;
            ativo        <= 1'b0;
            pronto       <= 1'b0;
            db_estado    <= '0;
        end else begin
            estado       <= estado_prox;
            ultimo       <= ultimo_prox;
            leds         <= leds_prox;
            mem_endereco <= endereco_prox;
            ativo        <= ativo_prox;
            pronto       <= pronto_prox;
            db_estado    <= db_prox;
        end
    end

    // Timer is loaded with interval-1 on entry, so each phase lasts exactly the interval
    always_comb begin
        estado_prox   = estado;
        ultimo_prox   = ultimo;
        leds_prox     = leds;
        endereco_prox = mem_endereco;
        t_zera        = 1'b0;
        t_conta       = 1'b0;
        t_valor       = CARGA_ACESO;

        case (estado)
            OCIOSO: begin
                leds_prox = '0;
                if (iniciar) begin
                    ultimo_prox   = tamanho;
                    endereco_prox = '0;
                    estado_prox   = CARREGA;
                end
            end
            CARREGA: begin
                leds_prox   = mem_dado;
                t_zera      = 1'b1;
                t_valor     = CARGA_ACESO;
                estado_prox = ACESO;
            end
            ACESO: begin
                if (t_fim) begin
                    leds_prox   = '0;
                    t_zera      = 1'b1;
                    t_valor     = CARGA_APAGADO;
                    estado_prox = APAGADO;
                end else begin
                    t_conta = 1'b1;
                end
            end
            APAGADO: begin
                if (t_fim) begin
                    if (mem_endereco == ultimo) begin
`ifdef EXIBIDOR_PISCA_FINAL_EN
                        leds_prox   = '1;
                        t_zera      = 1'b1;
                        t_valor     = CARGA_ACESO;
                        estado_prox = PISCA;
`else
                        estado_prox = FIM;
`endif
                    end else begin
                        endereco_prox = mem_endereco + LARG_DADO'(1);
                        estado_prox   = CARREGA;
                    end
                end else begin
                    t_conta = 1'b1;
                end
            end
`ifdef EXIBIDOR_PISCA_FINAL_EN
            PISCA: begin
                if (t_fim) begin
                    leds_prox   = '0;
                    estado_prox = FIM;
                end else begin
                    t_conta = 1'b1;
                end
            end
`endif
            FIM: begin
                leds_prox   = '0;
                estado_prox = OCIOSO;
            end
            default: begin
                leds_prox   = '0;
                estado_prox = OCIOSO;
            end
        endcase

        // Abort wins over everything, including a pending start
        if (parar) begin
            estado_prox   = OCIOSO;
            leds_prox     = '0;
            endereco_prox = '0;
        end

        ativo_prox  = (estado_prox == CARREGA) || (estado_prox == ACESO) ||
`ifdef EXIBIDOR_PISCA_FINAL_EN
                      (estado_prox == PISCA) ||
`endif
                      (estado_prox == APAGADO);
        pronto_prox = (estado_prox == FIM);
        db_prox     = LARG_DB'(estado_prox);
    end

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Directed self-checking bench for exibidor_sequencia with T_ACESO=4, T_APAGADO=2.
// Honours EXIBIDOR_PISCA_FINAL_EN by shifting the completion expectations.
module tb_exibidor_sequencia;

    localparam int unsigned TA = 4;
    localparam int unsigned TP = 2;
`ifdef EXIBIDOR_PISCA_FINAL_EN
    localparam int EXTRA = 4;
`else
    localparam int EXTRA = 0;
`endif

    logic       clock = 1'b0;
    logic       reset, iniciar, parar;
    logic [3:0] tamanho, mem_dado, mem_endereco, leds, db_estado;
    logic       ativo, pronto;
    logic [3:0] rom [16];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;
    assign mem_dado = rom[mem_endereco];

    exibidor_sequencia #(.T_ACESO(TA), .T_APAGADO(TP)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .parar        (parar),
        .tamanho      (tamanho),
        .mem_dado     (mem_dado),
        .mem_endereco (mem_endereco),
        .leds         (leds),
        .ativo        (ativo),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_cmp++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulses iniciar so that the next edge is the start edge; returns just after it (j=0)
    task automatic dispara(input logic [3:0] tam);
        tamanho = tam;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
    endtask

    logic [3:0] exp_l [21];
    int p_ciclo, n_pronto, n_ativo, n_aceso;

    initial begin
        exp_l = '{4'h0, 4'hA, 4'hA, 4'hA, 4'hA, 4'h0, 4'h0, 4'h0, 4'h5, 4'h5, 4'h5,
                  4'h5, 4'h0, 4'h0, 4'h0, 4'h3, 4'h3, 4'h3, 4'h3, 4'h0, 4'h0};
        for (int i = 0; i < 16; i++) rom[i] = 4'(i);
        rom[0] = 4'hA; rom[1] = 4'h5; rom[2] = 4'h3;
        reset = 1'b0; iniciar = 1'b0; parar = 1'b0; tamanho = 4'd0;

        #2;
        confere("rst_leds", 32'(leds), 32'h0);
        confere("rst_ativo", 32'(ativo), 32'h0);
        confere("rst_pronto", 32'(pronto), 32'h0);
        confere("rst_db", 32'(db_estado), 32'h0);
        confere("rst_end", 32'(mem_endereco), 32'h0);
        tick();
        reset = 1'b1;
        tick();

        // Three values A,5,3
        dispara(4'd2);
        confere("s1_ativo_j0", 32'(ativo), 32'h1);
        p_ciclo = -1; n_pronto = 0;
        for (int j = 0; j <= 40; j++) begin
            if (j <= 20) confere($sformatf("s1_leds_j%0d", j), 32'(leds), 32'(exp_l[j]));
            if (pronto) begin
                n_pronto++;
                if (p_ciclo < 0) p_ciclo = j;
            end
            tick();
        end
        confere("s1_pronto_ciclo", 32'(p_ciclo), 32'(21 + EXTRA));
        confere("s1_pronto_n", 32'(n_pronto), 32'd1);

        // Single zero-valued entry
        rom[0] = 4'h0;
        dispara(4'd0);
        p_ciclo = -1; n_ativo = 0; n_aceso = 0;
        for (int j = 0; j <= 30; j++) begin
            if (ativo) n_ativo++;
            if (leds != 4'h0) n_aceso++;
`ifdef EXIBIDOR_PISCA_FINAL_EN
            if (j == 7) confere("s2_pisca", 32'(leds), 32'hF);
`endif
            if (pronto && p_ciclo < 0) p_ciclo = j;
            tick();
        end
        confere("s2_ativo_n", 32'(n_ativo), 32'(7 + EXTRA));
        confere("s2_aceso_n", 32'(n_aceso), 32'(EXTRA));
        confere("s2_pronto_ciclo", 32'(p_ciclo), 32'(7 + EXTRA));

        // Abort during the second lit value, then restart
        rom[0] = 4'hA;
        dispara(4'd2);
        repeat (9) tick();
        confere("s3_leds_j9", 32'(leds), 32'h5);
        parar = 1'b1;
        tick();
        parar = 1'b0;
        confere("s3_leds", 32'(leds), 32'h0);
        confere("s3_ativo", 32'(ativo), 32'h0);
        confere("s3_db", 32'(db_estado), 32'h0);
        confere("s3_end", 32'(mem_endereco), 32'h0);
        n_pronto = 0;
        for (int j = 0; j < 30; j++) begin
            if (pronto) n_pronto++;
            tick();
        end
        confere("s3_sem_pronto", 32'(n_pronto), 32'd0);
        dispara(4'd2);
        tick();
        confere("s3_reinicio_leds", 32'(leds), 32'hA);
        confere("s3_reinicio_end", 32'(mem_endereco), 32'h0);
        parar = 1'b1;
        tick();
        parar = 1'b0;

        // iniciar held high, tamanho changed mid-playback
        tamanho = 4'd1;
        iniciar = 1'b1;
        tick();
        confere("s4_db_j0", 32'(db_estado), 32'h1);
        p_ciclo = -1; n_pronto = 0;
        for (int j = 0; j <= 16 + EXTRA; j++) begin
            if (j == 3) tamanho = 4'd3;
            if (j == 2) confere("s4_db_j2", 32'(db_estado), 32'h2);
            if (j == 8) confere("s4_leds_j8", 32'(leds), 32'h5);
            if (j == 15 + EXTRA) confere("s4_ocioso", 32'(ativo), 32'h0);
            if (j == 16 + EXTRA) confere("s4_reaceita", 32'(db_estado), 32'h1);
            if (pronto) begin
                n_pronto++;
                if (p_ciclo < 0) p_ciclo = j;
            end
            tick();
        end
        confere("s4_pronto_ciclo", 32'(p_ciclo), 32'(14 + EXTRA));
        confere("s4_pronto_n", 32'(n_pronto), 32'd1);
        iniciar = 1'b0;
        parar = 1'b1;
        tick();
        iniciar = 1'b1;
        repeat (3) tick();
        confere("s4_parar_inic_ativo", 32'(ativo), 32'h0);
        confere("s4_parar_inic_db", 32'(db_estado), 32'h0);
        iniciar = 1'b0;
        parar = 1'b0;
        tick();

        // Asynchronous reset mid-playback
        dispara(4'd2);
        repeat (3) tick();
        confere("s5_leds_antes", 32'(leds), 32'hA);
        reset = 1'b0;
        #1;
        confere("s5_leds", 32'(leds), 32'h0);
        confere("s5_ativo", 32'(ativo), 32'h0);
        confere("s5_db", 32'(db_estado), 32'h0);
        confere("s5_end", 32'(mem_endereco), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        confere("s5_ocioso", 32'(db_estado), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
